// File: rtl/serial_sub_if.sv
// serial_sub operand/result bundle.
// Requester drives start and operands; the subtractor returns status and result.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b - borrow_in, LSB first,
// one full-subtractor cell plus a registered borrow.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    serial_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic [WIDTH-1:0] sd_nxt;
    logic [WIDTH-1:0] diff_q;
    logic             br;
    logic             bo_q;
    logic [CW-1:0]    cnt;
    logic             x;
    logic             y;
    logic             z;
    logic             d;
    logic             bnext;
    logic             accept;
    logic             last;

    // full-subtractor cell
    assign x      = sa[0];
    assign y      = sb[0];
    assign z      = br;
    assign d      = x ^ y ^ z;
    assign bnext  = (~x & y) | (~(x ^ y) & z);
    assign sd_nxt = (sd >> 1) | (WIDTH'(d) << (WIDTH - 1));

    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = (state != BUSY) && bus.start;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start) state_nxt = BUSY;
            BUSY: if (last) state_nxt = DONE;
            DONE: state_nxt = bus.start ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bo_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sa  <= bus.a;
                sb  <= bus.b;
                br  <= bus.borrow_in;
                cnt <= '0;
            end else if (state == BUSY) begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                sd  <= sd_nxt;
                br  <= bnext;
                cnt <= cnt + CW'(1);
                // result registers only move on the edge into DONE
                if (last) begin
                    diff_q <= sd_nxt;
                    bo_q   <= bnext;
                end
            end
        end
    end

    assign bus.busy       = (state == BUSY);
    assign bus.done       = (state == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = bo_q;
endmodule
